// File: rtl/adc_pkg.sv
// Shared constants for the ADC decimation chain: chain word width, CIC order
// and the gain-alignment figures the half-band stages rely on.
package adc_pkg;

    localparam int ADC_DW           = 35;
    localparam int CIC_ORDER        = 5;
    localparam int CIC_DEC_LOG2_MAX = 6;
    localparam int CIC_DEC_LOG2_DEF = 6;
    localparam int MOD_IN_W_DEF     = 4;

    // Full-precision CIC gain in bits for the default configuration.
    localparam int CIC_GAIN_LOG2 = CIC_ORDER * CIC_DEC_LOG2_DEF;

    // Spare MSBs left in the chain word above a full-scale CIC output.
    localparam int HB_ALIGN_SHIFT = ADC_DW - (MOD_IN_W_DEF + CIC_GAIN_LOG2);

    typedef logic signed [ADC_DW-1:0] adc_word_t;

    function automatic int cic_acc_w(input int in_w, input int dec_log2);
        return in_w + CIC_ORDER * dec_log2;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: differentiator with a delay register that only
// advances on the decimated-rate enable.
module cic_comb_stage #(
    parameter int W = 34
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] dout
);

    logic signed [W-1:0] dly;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dly <= '0;
        end else if (en) begin
            dly <= din;
        end
    end

    assign dout = din - dly;

endmodule

// File: rtl/cic5_dec.sv
// Fifth-order CIC decimator, first stage of the ADC chain. Decimates the
// modulator stream by 2^DEC_LOG2 at full precision, wrap-around arithmetic.
module cic5_dec
    import adc_pkg::*;
#(
    parameter int IN_W     = 4,
    parameter int DEC_LOG2 = 6
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clk_vld_in,
    input  logic signed [IN_W-1:0]   dat_in,
    output logic                     clk_vld_out,
    output logic signed [ADC_DW-1:0] dat_out
);

    localparam int ACC_W = cic_acc_w(IN_W, DEC_LOG2);

    if (ACC_W > ADC_DW) begin : g_acc_w_chk
        $error("cic5_dec: accumulator width %0d exceeds chain width %0d", ACC_W, ADC_DW);
    end
    if (DEC_LOG2 < 1 || DEC_LOG2 > CIC_DEC_LOG2_MAX) begin : g_dec_chk
        $error("cic5_dec: DEC_LOG2 %0d out of range", DEC_LOG2);
    end

    logic signed [ACC_W-1:0]    integ [CIC_ORDER];
    logic signed [ACC_W-1:0]    sext_in;
    logic signed [ACC_W-1:0]    c_in;
    logic        [DEC_LOG2-1:0] ph;
    logic                       dec_ev;
    logic                       dec_d;

    assign sext_in = ACC_W'(dat_in);
    assign dec_ev  = clk_vld_in && (ph == '1);

    // Integrators read the previous value of the stage below (pipelined chain).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < CIC_ORDER; k++) begin
                integ[k] <= '0;
            end
        end else if (clk_vld_in) begin
            integ[0] <= integ[0] + sext_in;
            for (int k = 1; k < CIC_ORDER; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph <= '0;
        end else if (clk_vld_in) begin
            ph <= ph + DEC_LOG2'(1);
        end
    end

    // Capture the value I5 takes on this update, so the comb sees the R-th sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_in  <= '0;
            dec_d <= 1'b0;
        end else begin
            dec_d <= dec_ev;
            if (dec_ev) begin
                c_in <= integ[CIC_ORDER-1] + integ[CIC_ORDER-2];
            end
        end
    end

    for (genvar g = 0; g < CIC_ORDER; g++) begin : g_comb
        logic signed [ACC_W-1:0] c_src;
        logic signed [ACC_W-1:0] c_out;

        if (g == 0) begin : g_first
            assign c_src = c_in;
        end else begin : g_next
            assign c_src = g_comb[g-1].c_out;
        end

        cic_comb_stage #(
            .W (ACC_W)
        ) u_comb (
            .clk  (clk),
            .rstn (rstn),
            .en   (dec_d),
            .din  (c_src),
            .dout (c_out)
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dat_out     <= '0;
            clk_vld_out <= 1'b0;
        end else begin
            clk_vld_out <= dec_d;
            if (dec_d) begin
                dat_out <= ADC_DW'(g_comb[CIC_ORDER-1].c_out);
            end
        end
    end

endmodule

// File: tb/tb_cic5_dec.sv
// Self-checking bench for cic5_dec: wide-integer reference model feeds a
// scoreboard of expected output values and strobe cycles.
module tb_cic5_dec;

    localparam int IN_W     = 4;
    localparam int DEC_LOG2 = 6;
    localparam int R        = 64;
    localparam int ACC_W    = 34;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b1;
    logic                   clk_vld_in = 1'b0;
    logic signed [IN_W-1:0] dat_in = '0;
    logic                   clk_vld_out;
    logic signed [34:0]     dat_out;

    always #5 clk = ~clk;

    cic5_dec #(
        .IN_W     (IN_W),
        .DEC_LOG2 (DEC_LOG2)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .clk_vld_in  (clk_vld_in),
        .dat_in      (dat_in),
        .clk_vld_out (clk_vld_out),
        .dat_out     (dat_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        longint val;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    longint obs[$];
    longint cyc = 0;
    bit     mon_en = 1'b0;
    bit     prev_vld = 1'b0;
    longint hold_val = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: 64-bit integrators (modular), truncated to ACC_W at the end.
    longint m_int[5];
    longint m_dly[5];
    int     m_ph;
    longint first_exp;
    bit     first_seen;

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_int[k] = 0;
            m_dly[k] = 0;
        end
        m_ph = 0;
    endtask

    task automatic model_sample(input int x, input longint now);
        longint nxt[5];
        longint c;
        longint t;
        logic signed [ACC_W-1:0] tr;
        exp_t e;
        nxt[0] = m_int[0] + longint'(x);
        for (int k = 1; k < 5; k++) nxt[k] = m_int[k] + m_int[k-1];
        for (int k = 0; k < 5; k++) m_int[k] = nxt[k];
        if (m_ph == R - 1) begin
            m_ph = 0;
            c = m_int[4];
            for (int k = 0; k < 5; k++) begin
                t = c - m_dly[k];
                m_dly[k] = c;
                c = t;
            end
            tr = c[ACC_W-1:0];
            e.val = tr;
            e.cyc = now + 2;
            sb.push_back(e);
            if (!first_seen) begin
                first_exp  = e.val;
                first_seen = 1'b1;
            end
        end else begin
            m_ph++;
        end
    endtask

    task automatic drive(input bit v, input int x);
        @(negedge clk);
        clk_vld_in = v;
        dat_in     = x[IN_W-1:0];
        if (v) model_sample(x, cyc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn       = 1'b0;
        clk_vld_in = 1'b0;
        dat_in     = '0;
        model_reset();
        sb.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        obs.delete();
    endtask

    task automatic drain();
        repeat (4) drive(1'b0, 0);
        check_val("drain_pending", sb.size(), 0);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (!rstn) begin
                check_val("rst_dat", dat_out, 0);
                check_val("rst_vld", longint'(clk_vld_out), 0);
                hold_val = 0;
                prev_vld = 1'b0;
            end else if (clk_vld_out) begin
                check_val("strobe_gap", longint'(prev_vld), 0);
                check_val("strobe_pending", sb.size(), 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val("out_val", dat_out, e.val);
                    check_val("out_cyc", cyc, e.cyc);
                end
                hold_val = dat_out;
                obs.push_back(dat_out);
                prev_vld = 1'b1;
            end else begin
                check_val("out_hold", dat_out, hold_val);
                prev_vld = 1'b0;
            end
        end
    end

    initial begin
        int     acc;
        int     guard;
        bit     v;
        longint step_first;

        first_seen = 1'b0;
        model_reset();
        #2;
        rstn   = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // positive step at full rate
        repeat (12 * R) drive(1'b1, 1);
        drain();
        step_first = first_exp;
        check_val("step_count", obs.size(), 12);
        for (int i = 1; i < obs.size(); i++)
            if (obs[i] < obs[i-1]) check_val("step_monotonic", obs[i], obs[i-1]);
        for (int i = 7; i < obs.size(); i++) check_val("step_settled", obs[i], 64'sd1073741824);

        // negative full-scale step, long enough to wrap the integrators
        do_reset();
        repeat (160 * R) drive(1'b1, -8);
        drain();
        check_val("neg_count", obs.size(), 160);
        for (int i = 7; i < obs.size(); i++) check_val("neg_settled", obs[i], -64'sd8589934592);

        // gapped input, ~1 in 3 cycles
        do_reset();
        acc   = 0;
        guard = 0;
        while (acc < 12 * R && guard < 20000) begin
            v = ($urandom_range(0, 2) == 0);
            drive(v, 1);
            if (v) acc++;
            guard++;
        end
        check_val("gap_accepted", acc, 12 * R);
        drain();
        check_val("gap_count", obs.size(), 12);
        if (obs.size() > 0) check_val("gap_first", obs[0], step_first);
        for (int i = 7; i < obs.size(); i++) check_val("gap_settled", obs[i], 64'sd1073741824);

        // zero-mean alternating stream
        do_reset();
        for (int i = 0; i < 10 * R; i++) drive(1'b1, (i % 2 == 0) ? 1 : -1);
        drain();
        check_val("zm_count", obs.size(), 10);
        for (int i = 5; i < obs.size(); i++) check_val("zm_zero", obs[i], 0);

        // reset pulsed at accepted sample 100
        do_reset();
        for (int i = 0; i < 100; i++) drive(1'b1, 1);
        check_val("mid_pre_count", obs.size(), 1);
        do_reset();
        for (int i = 0; i < R - 1; i++) drive(1'b1, 1);
        repeat (4) drive(1'b0, 0);
        check_val("mid_early", obs.size(), 0);
        drive(1'b1, 1);
        drain();
        check_val("mid_count", obs.size(), 1);
        if (obs.size() > 0) check_val("mid_first", obs[0], step_first);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
